// File: rtl/wdata_chan_rcvr_pkg.sv
// Shared types and constants for the write data channel receiver.
// State encodings, B-channel response codes and burst length.
package wdata_chan_rcvr_pkg;

  localparam int BURST_LEN = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RECV  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_t;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;

endpackage

// File: rtl/wbeat_assembler.sv
// Beat counter and lane packer for a 4 x 32-bit write burst.
// Flags burst end and early/missing wlast errors.
module wbeat_assembler (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         beat_en,
  input  logic [31:0]  wdata,
  input  logic         wlast,
  output logic [127:0] wbuf,
  output logic         burst_end,
  output logic         err
);

  logic [1:0] cnt;
  logic       err_q;
  logic       cnt3;
  logic       err_now;

  assign cnt3      = (cnt == 2'd3);
  assign burst_end = beat_en & (cnt3 | wlast);
  // wlast must coincide with the fourth beat exactly
  assign err_now   = beat_en & (cnt3 ^ wlast);
  assign err       = err_q | err_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      err_q <= 1'b0;
      wbuf  <= '0;
    end else if (clear) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else if (beat_en) begin
      wbuf[{cnt, 5'b0} +: 32] <= wdata;
      cnt <= cnt + 2'd1;
      if (err_now) err_q <= 1'b1;
    end
  end

endmodule

// File: rtl/wdata_chan_rcvr.sv
// Slave-side write data receiver: collects a 4-beat burst,
// issues one 128-bit memory write, then returns a B response.
module wdata_chan_rcvr #(
  parameter int BURST_LEN = 4,
  parameter int ID_W      = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            aw_rq,
  input  logic [ID_W-1:0] aw_id,
  input  logic [31:0]     aw_addr,
  output logic            aw_busy,
  input  logic            wvalid,
  output logic            wready,
  input  logic [31:0]     wdata,
  input  logic            wlast,
  output logic            bvalid,
  input  logic            bready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [127:0]    mem_wdata
);

  import wdata_chan_rcvr_pkg::*;

  if (BURST_LEN != wdata_chan_rcvr_pkg::BURST_LEN) begin : g_bad_cfg
    $error("wdata_chan_rcvr: only BURST_LEN=4 is supported");
  end

  state_t          state;
  state_t          state_nxt;
  logic [ID_W-1:0] id_q;
  logic [31:0]     addr_q;
  logic            accept;
  logic            beat_en;
  logic            burst_end;
  logic            err;
  logic [127:0]    wbuf;

  assign wready  = (state == RECV);
  assign mem_we  = (state == WRITE);
  assign bvalid  = (state == RESP);
  assign aw_busy = ~((state == IDLE) | ((state == RESP) & bready));
  assign accept  = aw_rq & ~aw_busy;
  assign beat_en = wvalid & wready;

  assign bid       = id_q;
  assign bresp     = (bvalid & err) ? BRESP_SLVERR : BRESP_OKAY;
  assign mem_addr  = addr_q;
  assign mem_wdata = wbuf;

  wbeat_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (accept),
    .beat_en   (beat_en),
    .wdata     (wdata),
    .wlast     (wlast),
    .wbuf      (wbuf),
    .burst_end (burst_end),
    .err       (err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      id_q   <= '0;
      addr_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        id_q   <= aw_id;
        addr_q <= aw_addr;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (aw_rq) state_nxt = RECV;
      RECV:  if (burst_end) state_nxt = err ? RESP : WRITE;
      WRITE: state_nxt = RESP;
      RESP:  if (bready) state_nxt = aw_rq ? RECV : IDLE;
    endcase
  end

endmodule

// File: tb/tb_wdata_chan_rcvr.sv
// Directed self-checking bench for wdata_chan_rcvr.
// Inputs driven on negedge; monitor records handshakes on posedge.
module tb_wdata_chan_rcvr;

  logic         clk;
  logic         rst_n;
  logic         aw_rq;
  logic [3:0]   aw_id;
  logic [31:0]  aw_addr;
  logic         aw_busy;
  logic         wvalid;
  logic         wready;
  logic [31:0]  wdata;
  logic         wlast;
  logic         bvalid;
  logic         bready;
  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int acc_n  = 0;
  int we_base;
  logic [31:0]  acc [16];
  logic [127:0] we_data;
  logic [31:0]  we_addr;
  logic [31:0]  bd [4];
  int pat [7] = '{1, 0, 0, 1, 1, 0, 1};

  wdata_chan_rcvr #(.BURST_LEN(4), .ID_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .aw_rq     (aw_rq),
    .aw_id     (aw_id),
    .aw_addr   (aw_addr),
    .aw_busy   (aw_busy),
    .wvalid    (wvalid),
    .wready    (wready),
    .wdata     (wdata),
    .wlast     (wlast),
    .bvalid    (bvalid),
    .bready    (bready),
    .bid       (bid),
    .bresp     (bresp),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n) begin
      if (wvalid && wready) begin
        if (acc_n < 16) acc[acc_n] = wdata;
        acc_n++;
      end
      if (mem_we) begin
        we_cnt++;
        we_data = mem_wdata;
        we_addr = mem_addr;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_aw(input logic [3:0] id, input logic [31:0] addr);
    @(negedge clk);
    aw_rq   = 1'b1;
    aw_id   = id;
    aw_addr = addr;
    @(negedge clk);
    aw_rq = 1'b0;
  endtask

  task automatic send_beats(input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      wvalid = 1'b1;
      wdata  = bd[i];
      wlast  = (i == last_at);
      @(negedge clk);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic wait_bvalid(input int max);
    int n = 0;
    while (!bvalid && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("bvalid_seen", {127'b0, bvalid}, 128'd1);
  endtask

  initial begin
    rst_n = 1'b0; aw_rq = 1'b0; aw_id = '0; aw_addr = '0;
    wvalid = 1'b0; wdata = '0; wlast = 1'b0; bready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_wready", {127'b0, wready}, 128'd0);
    chk("rst_bvalid", {127'b0, bvalid}, 128'd0);
    chk("rst_mem_we", {127'b0, mem_we}, 128'd0);
    chk("rst_aw_busy", {127'b0, aw_busy}, 128'd0);
    chk("rst_bid", {124'b0, bid}, 128'd0);
    chk("rst_mem_wdata", mem_wdata, 128'd0);
    rst_n = 1'b1;

    // basic burst, exact latency
    bready = 1'b1;
    bd = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    start_aw(4'h5, 32'h0000_1000);
    chk("basic_wready", {127'b0, wready}, 128'd1);
    chk("basic_busy", {127'b0, aw_busy}, 128'd1);
    send_beats(4, 3);
    chk("basic_we", {127'b0, mem_we}, 128'd1);
    chk("basic_addr", {96'b0, mem_addr}, 128'h1000);
    chk("basic_data", mem_wdata,
        128'h44444444_33333333_22222222_11111111);
    chk("basic_wready_off", {127'b0, wready}, 128'd0);
    @(negedge clk);
    chk("basic_bvalid", {127'b0, bvalid}, 128'd1);
    chk("basic_bid", {124'b0, bid}, 128'h5);
    chk("basic_bresp", {126'b0, bresp}, 128'd0);
    @(negedge clk);
    chk("basic_idle_bv", {127'b0, bvalid}, 128'd0);
    chk("basic_idle_busy", {127'b0, aw_busy}, 128'd0);

    // stalled handshake with bready low for 3 cycles
    bready = 1'b0;
    acc_n = 0;
    we_base = we_cnt;
    bd = '{32'hA0000001, 32'hB0000002, 32'hC0000003, 32'hD0000004};
    start_aw(4'hA, 32'h0000_2000);
    begin
      int k = 0;
      for (int c = 0; c < 7; c++) begin
        wvalid = pat[c][0];
        wdata  = bd[k];
        wlast  = (k == 3);
        @(negedge clk);
        if (pat[c] == 1 && k < 3) k++;
      end
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    wait_bvalid(10);
    for (int i = 0; i < 3; i++) begin
      chk("stall_bvalid", {127'b0, bvalid}, 128'd1);
      chk("stall_bid", {124'b0, bid}, 128'hA);
      chk("stall_bresp", {126'b0, bresp}, 128'd0);
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    chk("stall_bv_drop", {127'b0, bvalid}, 128'd0);
    chk("stall_beats", acc_n, 4);
    for (int i = 0; i < 4; i++) chk("stall_order", {96'b0, acc[i]}, {96'b0, bd[i]});
    chk("stall_one_we", we_cnt - we_base, 1);
    chk("stall_data", we_data,
        128'hD0000004_C0000003_B0000002_A0000001);
    chk("stall_addr", {96'b0, we_addr}, 128'h2000);

    // early wlast on beat 2
    we_base = we_cnt;
    start_aw(4'h9, 32'h0000_2400);
    send_beats(2, 1);
    chk("early_wready", {127'b0, wready}, 128'd0);
    chk("early_bvalid", {127'b0, bvalid}, 128'd1);
    chk("early_bresp", {126'b0, bresp}, 128'h2);
    chk("early_bid", {124'b0, bid}, 128'h9);
    @(negedge clk);
    chk("early_no_we", we_cnt - we_base, 0);

    // missing wlast
    bready = 1'b0;
    start_aw(4'hC, 32'h0000_2800);
    send_beats(4, -1);
    chk("miss_bvalid", {127'b0, bvalid}, 128'd1);
    chk("miss_bresp", {126'b0, bresp}, 128'h2);
    chk("miss_no_we", we_cnt - we_base, 0);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("miss_idle_bv", {127'b0, bvalid}, 128'd0);
    chk("miss_idle_busy", {127'b0, aw_busy}, 128'd0);

    // back-to-back: new aw_rq in the bready cycle
    bd = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404};
    start_aw(4'h3, 32'h0000_3000);
    send_beats(4, 3);
    wait_bvalid(5);
    chk("b2b_bid1", {124'b0, bid}, 128'h3);
    chk("b2b_bresp1", {126'b0, bresp}, 128'd0);
    bready  = 1'b1;
    aw_rq   = 1'b1;
    aw_id   = 4'h7;
    aw_addr = 32'h0000_4000;
    #1;
    chk("b2b_busy", {127'b0, aw_busy}, 128'd0);
    @(negedge clk);
    aw_rq = 1'b0;
    chk("b2b_recv", {127'b0, wready}, 128'd1);
    chk("b2b_bv_drop", {127'b0, bvalid}, 128'd0);
    bd = '{32'h70000000, 32'h71111111, 32'h72222222, 32'h73333333};
    send_beats(4, 3);
    wait_bvalid(5);
    chk("b2b_bid2", {124'b0, bid}, 128'h7);
    chk("b2b_bresp2", {126'b0, bresp}, 128'd0);
    chk("b2b_addr2", {96'b0, we_addr}, 128'h4000);
    chk("b2b_data2", we_data,
        128'h73333333_72222222_71111111_70000000);

    // reset mid-burst
    @(negedge clk);
    we_base = we_cnt;
    start_aw(4'h2, 32'h0000_5000);
    send_beats(2, -1);
    rst_n = 1'b0;
    #1;
    chk("mrst_wready", {127'b0, wready}, 128'd0);
    chk("mrst_bvalid", {127'b0, bvalid}, 128'd0);
    chk("mrst_busy", {127'b0, aw_busy}, 128'd0);
    chk("mrst_bid", {124'b0, bid}, 128'd0);
    chk("mrst_addr", {96'b0, mem_addr}, 128'd0);
    chk("mrst_data", mem_wdata, 128'd0);
    chk("mrst_no_we", we_cnt - we_base, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bd = '{32'h600D0001, 32'h600D0002, 32'h600D0003, 32'h600D0004};
    start_aw(4'h6, 32'h0000_6000);
    send_beats(4, 3);
    chk("post_we", {127'b0, mem_we}, 128'd1);
    chk("post_addr", {96'b0, mem_addr}, 128'h6000);
    chk("post_data", mem_wdata,
        128'h600D0004_600D0003_600D0002_600D0001);
    @(negedge clk);
    chk("post_bvalid", {127'b0, bvalid}, 128'd1);
    chk("post_bid", {124'b0, bid}, 128'h6);
    chk("post_bresp", {126'b0, bresp}, 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
